// File: rtl/pong_game_ctrl.sv
// ---------------------------------------------------------------------------
// pong_game_ctrl
//
// Game-sequencing controller for the single-player paddle/ball datapath.
// Runs the game state machine (idle, serve delay, play, miss pause, game
// over). It gates ball/paddle motion, commands ball re-centring, schedules
// ball speed-up from paddle hits, and keeps score, lives and high score.
// All outputs are registered, so they update one clock after the input that
// caused the change.
//
// Ports
//   clk              pixel clock
//   reset            asynchronous, active-high reset
//   i_refresh_tick   one-cycle pulse per frame (vertical-blank start)
//   i_start          one-cycle debounced start-button pulse
//   i_paddle_hit     one-cycle pulse, ball struck paddle
//   i_ball_miss      one-cycle pulse, ball passed right edge
//   o_state          IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4
//   o_run            1 = datapath may move ball/paddle (PLAY only)
//   o_ball_reset     1 = datapath holds ball and paddle at home position
//   o_speed          ball velocity magnitude, unsigned
//   o_hit_count      paddle hits this game (score), saturating
//   o_high_score     best hit_count since reset
//   o_lives          remaining lives
//   o_game_over      1 while in OVER
// ---------------------------------------------------------------------------
module pong_game_ctrl #(
   parameter int SPEED_INIT     = 2,
   parameter int SPEED_MAX      = 6,
   parameter int HITS_PER_LEVEL = 5,
   parameter int SERVE_FRAMES   = 60,
   parameter int MISS_FRAMES    = 90,
   parameter int OVER_FRAMES    = 300,
   parameter int LIVES_INIT     = 3,
   parameter int CNT_W          = 11
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_refresh_tick,
   input  logic             i_start,
   input  logic             i_paddle_hit,
   input  logic             i_ball_miss,
   output logic [2:0]       o_state,
   output logic             o_run,
   output logic             o_ball_reset,
   output logic [9:0]       o_speed,
   output logic [CNT_W-1:0] o_hit_count,
   output logic [CNT_W-1:0] o_high_score,
   output logic [2:0]       o_lives,
   output logic             o_game_over
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SERVE = 3'd1,
      S_PLAY  = 3'd2,
      S_MISS  = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   localparam int LVL_W = $clog2(HITS_PER_LEVEL) + 1;

   localparam logic [9:0]       SPEED_INIT_V = 10'(SPEED_INIT);
   localparam logic [9:0]       SPEED_MAX_V  = 10'(SPEED_MAX);
   localparam logic [2:0]       LIVES_INIT_V = 3'(LIVES_INIT);
   localparam logic [9:0]       SERVE_LAST   = 10'(SERVE_FRAMES - 1);
   localparam logic [9:0]       MISS_LAST    = 10'(MISS_FRAMES - 1);
   localparam logic [9:0]       OVER_LAST    = 10'(OVER_FRAMES - 1);
   localparam logic [LVL_W-1:0] LEVEL_LAST   = LVL_W'(HITS_PER_LEVEL - 1);
   localparam logic [CNT_W-1:0] HIT_SAT      = '1;

   state_t           r_state;
   logic             r_run;
   logic             r_ball_reset;
   logic             r_game_over;
   logic [9:0]       r_speed;
   logic [9:0]       r_frame_cnt;
   logic [CNT_W-1:0] r_hit_count;
   logic [CNT_W-1:0] r_high_score;
   logic [2:0]       r_lives;
   logic [LVL_W-1:0] r_level_hits;

   // Terminal-count detects for the three timed states; the transition fires
   // on the refresh tick that arrives while the counter sits at N-1.
   logic w_serve_done;
   logic w_miss_done;
   logic w_over_done;
   logic w_hit_sat;
   logic w_level_up;
   logic w_last_life;
   logic w_new_high;

   assign w_serve_done = (r_frame_cnt == SERVE_LAST);
   assign w_miss_done  = (r_frame_cnt == MISS_LAST);
   assign w_over_done  = (r_frame_cnt == OVER_LAST);
   assign w_hit_sat    = (r_hit_count == HIT_SAT);
   assign w_level_up   = (r_level_hits == LEVEL_LAST);
   assign w_last_life  = (r_lives == 3'd1);
   assign w_new_high   = (r_hit_count > r_high_score);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_run        <= 1'b0;
         r_ball_reset <= 1'b1;
         r_game_over  <= 1'b0;
         r_speed      <= SPEED_INIT_V;
         r_frame_cnt  <= '0;
         r_hit_count  <= '0;
         r_high_score <= '0;
         r_lives      <= LIVES_INIT_V;
         r_level_hits <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state      <= S_SERVE;
                  r_lives      <= LIVES_INIT_V;
                  r_hit_count  <= '0;
                  r_speed      <= SPEED_INIT_V;
                  r_level_hits <= '0;
                  r_frame_cnt  <= '0;
               end
            end

            S_SERVE: begin
               if (i_refresh_tick) begin
                  if (w_serve_done) begin
                     r_state      <= S_PLAY;
                     r_frame_cnt  <= '0;
                     r_run        <= 1'b1;
                     r_ball_reset <= 1'b0;
                  end else begin
                     r_frame_cnt <= r_frame_cnt + 10'd1;
                  end
               end
            end

            S_PLAY: begin
               // A miss takes priority; a hit in the same cycle is dropped.
               if (i_ball_miss) begin
                  r_lives      <= r_lives - 3'd1;
                  r_frame_cnt  <= '0;
                  r_run        <= 1'b0;
                  r_ball_reset <= 1'b1;
                  if (w_last_life) begin
                     r_state     <= S_OVER;
                     r_game_over <= 1'b1;
                     if (w_new_high) begin
                        r_high_score <= r_hit_count;
                     end
                  end else begin
                     r_state      <= S_MISS;
                     r_speed      <= SPEED_INIT_V;
                     r_level_hits <= '0;
                  end
               end else if (i_paddle_hit) begin
                  if (!w_hit_sat) begin
                     r_hit_count <= r_hit_count + 1'b1;
                  end
                  // level_hits keeps cycling at top speed; only speed saturates.
                  if (w_level_up) begin
                     r_level_hits <= '0;
                     if (r_speed < SPEED_MAX_V) begin
                        r_speed <= r_speed + 10'd1;
                     end
                  end else begin
                     r_level_hits <= r_level_hits + 1'b1;
                  end
               end
            end

            S_MISS: begin
               if (i_refresh_tick) begin
                  if (w_miss_done) begin
                     r_state     <= S_SERVE;
                     r_frame_cnt <= '0;
                  end else begin
                     r_frame_cnt <= r_frame_cnt + 10'd1;
                  end
               end
            end

            S_OVER: begin
               // Score and lives stay visible until the next start.
               if (i_refresh_tick) begin
                  if (w_over_done) begin
                     r_state     <= S_IDLE;
                     r_frame_cnt <= '0;
                     r_game_over <= 1'b0;
                  end else begin
                     r_frame_cnt <= r_frame_cnt + 10'd1;
                  end
               end
            end

            default: begin
               // Encodings 5-7 recover to IDLE with safe outputs.
               r_state      <= S_IDLE;
               r_run        <= 1'b0;
               r_ball_reset <= 1'b1;
               r_game_over  <= 1'b0;
               r_frame_cnt  <= '0;
            end
         endcase
      end
   end

   assign o_state      = r_state;
   assign o_run        = r_run;
   assign o_ball_reset = r_ball_reset;
   assign o_speed      = r_speed;
   assign o_hit_count  = r_hit_count;
   assign o_high_score = r_high_score;
   assign o_lives      = r_lives;
   assign o_game_over  = r_game_over;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pong_game_ctrl
//
// Self-checking bench for pong_game_ctrl. A behavioural game model (ticks
// remaining per phase, hits since the last serve reset, speed derived from
// that count) predicts every output after every clock. Directed phases walk
// through the game scenarios; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_pong_game_ctrl;

   localparam int SPEED_INIT     = 2;
   localparam int SPEED_MAX      = 6;
   localparam int HITS_PER_LEVEL = 5;
   localparam int SERVE_FRAMES   = 60;
   localparam int MISS_FRAMES    = 90;
   localparam int OVER_FRAMES    = 300;
   localparam int LIVES_INIT     = 3;
   localparam int CNT_W          = 11;
   localparam int HIT_CAP        = (1 << CNT_W) - 1;

   logic             clk;
   logic             reset;
   logic             refresh_tick;
   logic             start;
   logic             paddle_hit;
   logic             ball_miss;
   logic [2:0]       state;
   logic             run;
   logic             ball_reset;
   logic [9:0]       speed;
   logic [CNT_W-1:0] hit_count;
   logic [CNT_W-1:0] high_score;
   logic [2:0]       lives;
   logic             game_over;

   pong_game_ctrl #(
      .SPEED_INIT    (SPEED_INIT),
      .SPEED_MAX     (SPEED_MAX),
      .HITS_PER_LEVEL(HITS_PER_LEVEL),
      .SERVE_FRAMES  (SERVE_FRAMES),
      .MISS_FRAMES   (MISS_FRAMES),
      .OVER_FRAMES   (OVER_FRAMES),
      .LIVES_INIT    (LIVES_INIT),
      .CNT_W         (CNT_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .i_refresh_tick(refresh_tick),
      .i_start       (start),
      .i_paddle_hit  (paddle_hit),
      .i_ball_miss   (ball_miss),
      .o_state       (state),
      .o_run         (run),
      .o_ball_reset  (ball_reset),
      .o_speed       (speed),
      .o_hit_count   (hit_count),
      .o_high_score  (high_score),
      .o_lives       (lives),
      .o_game_over   (game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode: 0 idle, 1 serve, 2 play, 3 miss, 4 over
   int m_mode;
   int m_left;   // refresh ticks still needed to leave the current timed phase
   int m_lives;
   int m_hits;
   int m_since;  // paddle hits since game start or last miss
   int m_high;

   function automatic int m_speed();
      int s;
      s = SPEED_INIT + m_since / HITS_PER_LEVEL;
      return (s > SPEED_MAX) ? SPEED_MAX : s;
   endfunction

   int m_speed_hold;  // speed is frozen in OVER (not reset on the final miss)

   task automatic model_reset();
      m_mode = 0; m_left = 0; m_lives = LIVES_INIT; m_hits = 0;
      m_since = 0; m_high = 0; m_speed_hold = SPEED_INIT;
   endtask

   task automatic model_step(input bit s, input bit t, input bit h, input bit m);
      case (m_mode)
         0: if (s) begin
               m_mode = 1; m_left = SERVE_FRAMES; m_lives = LIVES_INIT;
               m_hits = 0; m_since = 0; m_speed_hold = SPEED_INIT;
            end
         1: if (t) begin
               m_left--;
               if (m_left == 0) m_mode = 2;
            end
         2: if (m) begin
               m_lives--;
               if (m_lives == 0) begin
                  m_mode = 4; m_left = OVER_FRAMES;
                  m_speed_hold = m_speed();
                  if (m_hits > m_high) m_high = m_hits;
               end else begin
                  m_mode = 3; m_left = MISS_FRAMES; m_since = 0;
               end
            end else if (h) begin
               if (m_hits < HIT_CAP) m_hits++;
               m_since++;
            end
         3: if (t) begin
               m_left--;
               if (m_left == 0) begin m_mode = 1; m_left = SERVE_FRAMES; end
            end
         default: if (t) begin
               m_left--;
               if (m_left == 0) m_mode = 0;
            end
      endcase
   endtask

   task automatic check_all();
      chk("state",      int'(state),      m_mode);
      chk("run",        int'(run),        (m_mode == 2) ? 1 : 0);
      chk("ball_reset", int'(ball_reset), (m_mode == 2) ? 0 : 1);
      chk("game_over",  int'(game_over),  (m_mode == 4) ? 1 : 0);
      chk("speed",      int'(speed),      (m_mode == 4) ? m_speed_hold : m_speed());
      chk("hit_count",  int'(hit_count),  m_hits);
      chk("high_score", int'(high_score), m_high);
      chk("lives",      int'(lives),      m_lives);
   endtask

   // One clock with the given input pulses, then model update and full check.
   task automatic cyc(input bit s, input bit t, input bit h, input bit m);
      start = s; refresh_tick = t; paddle_hit = h; ball_miss = m;
      @(posedge clk);
      model_step(s, t, h, m);
      #1;
      check_all();
      start = 0; refresh_tick = 0; paddle_hit = 0; ball_miss = 0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cyc(0, 1, 0, 0);
   endtask

   task automatic hits(input int n);
      for (int i = 0; i < n; i++) cyc(0, ($urandom % 2) == 0, 1, 0);
   endtask

   initial begin
      reset = 1; start = 0; refresh_tick = 0; paddle_hit = 0; ball_miss = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 0;
      check_all();

      // Idle with no stimulus, then ticks ignored in IDLE.
      for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
      chk("idle_state", int'(state), 0);
      chk("idle_speed", int'(speed), 2);
      cyc(0, 1, 1, 1);

      // Game A: serve timing, speed-up, async reset in PLAY.
      cyc(1, 0, 0, 0);
      chk("start_serve", int'(state), 1);
      ticks(59);
      chk("serve_59", int'(state), 1);
      ticks(1);
      chk("serve_60_state", int'(state), 2);
      chk("serve_60_run", int'(run), 1);
      hits(12);
      chk("hits12_count", int'(hit_count), 12);
      chk("hits12_speed", int'(speed), 4);
      #2 reset = 1;
      #1;
      model_reset();
      check_all();
      chk("async_speed", int'(speed), 2);
      @(posedge clk);
      #1 reset = 0;

      // Game B: simultaneous hit+miss, misses down to OVER.
      cyc(1, 0, 0, 0);
      ticks(SERVE_FRAMES);
      hits(7);
      cyc(0, 0, 1, 1);
      chk("hitmiss_count", int'(hit_count), 7);
      chk("hitmiss_lives", int'(lives), 2);
      chk("hitmiss_state", int'(state), 3);
      chk("hitmiss_speed", int'(speed), 2);
      ticks(89);
      chk("miss_89", int'(state), 3);
      ticks(1);
      chk("miss_90", int'(state), 1);
      ticks(SERVE_FRAMES);
      hits(2);
      cyc(0, 1, 0, 1);
      ticks(MISS_FRAMES + SERVE_FRAMES);
      cyc(0, 0, 0, 1);
      chk("over_state", int'(state), 4);
      chk("over_flag", int'(game_over), 1);
      chk("over_lives", int'(lives), 0);
      chk("over_high", int'(high_score), 9);
      cyc(1, 0, 1, 1);
      chk("over_start_ign", int'(state), 4);
      ticks(OVER_FRAMES - 1);
      chk("over_299", int'(state), 4);
      ticks(1);
      chk("over_done", int'(state), 0);
      chk("over_keep_hits", int'(hit_count), 9);

      // Game C: speed saturation.
      cyc(1, 0, 0, 0);
      ticks(SERVE_FRAMES);
      hits(37);
      chk("sat_speed", int'(speed), 6);
      chk("sat_count", int'(hit_count), 37);

      // Randomized play.
      for (int i = 0; i < 6000; i++) begin
         cyc(($urandom % 25) == 0, ($urandom % 2) == 0,
             ($urandom % 3) == 0, ($urandom % 40) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
